data_mem_controller: RTL

// - Arbitrates per-thread LSU data-memory requests from all cores onto a smaller set of external memory channels.
// - Sits between the cores' data_mem_* buses and the external data memory.
// - Each channel serves one consumer at a time, end to end, and carries that consumer's request and response.

---
 rtl/data_mem_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/data_mem_controller.sv
// Multi-channel data-memory arbiter: fixed-priority mapping of per-thread LSU
// read/write requests onto NUM_CHANNELS external memory channels.
module data_mem_controller #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned NUM_CHANNELS  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]              mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_read_address,
  input  logic [NUM_CHANNELS-1:0]              mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_read_data,
  output logic [NUM_CHANNELS-1:0]              mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_write_data,
  input  logic [NUM_CHANNELS-1:0]              mem_write_ready
);

  localparam int unsigned OWNER_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } state_t;

  state_t                          state_q [NUM_CHANNELS];
  state_t                          state_n [NUM_CHANNELS];
  logic [OWNER_BITS-1:0]           owner_q [NUM_CHANNELS];
  logic [OWNER_BITS-1:0]           owner_n [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]            addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]            addr_n  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]            wdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0]            wdata_n [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]        claim_q, claim_n, taken;
  logic [NUM_CONSUMERS-1:0]        read_ready_n, write_ready_n;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_n;
  logic                            found;

  // Next-state: channels pick in ascending order; 'taken' excludes consumers
  // already claimed or picked by a lower channel this cycle.
  always_comb begin
    state_n       = state_q;
    owner_n       = owner_q;
    addr_n        = addr_q;
    wdata_n       = wdata_q;
    claim_n       = claim_q;
    taken         = claim_q;
    read_ready_n  = consumer_read_ready;
    write_ready_n = consumer_write_ready;
    read_data_n   = consumer_read_data;
    found         = 1'b0;
    for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
      found = 1'b0;
      case (state_q[ch])
        IDLE: begin
          for (int c = 0; c < int'(NUM_CONSUMERS); c++) begin
            if (!found && !taken[c] && (consumer_read_valid[c] || consumer_write_valid[c])) begin
              found       = 1'b1;
              taken[c]    = 1'b1;
              claim_n[c]  = 1'b1;
              owner_n[ch] = OWNER_BITS'(c);
              wdata_n[ch] = consumer_write_data[c*DATA_BITS +: DATA_BITS];
              if (consumer_read_valid[c]) begin
                addr_n[ch]  = consumer_read_address[c*ADDR_BITS +: ADDR_BITS];
                state_n[ch] = READ_WAITING;
              end else begin
                addr_n[ch]  = consumer_write_address[c*ADDR_BITS +: ADDR_BITS];
                state_n[ch] = WRITE_WAITING;
              end
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[ch]) begin
            read_data_n[int'(owner_q[ch])*DATA_BITS +: DATA_BITS] =
              mem_read_data[ch*DATA_BITS +: DATA_BITS];
            read_ready_n[owner_q[ch]] = 1'b1;
            state_n[ch] = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[ch]) begin
            write_ready_n[owner_q[ch]] = 1'b1;
            state_n[ch] = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[owner_q[ch]]) begin
            read_ready_n[owner_q[ch]] = 1'b0;
            claim_n[owner_q[ch]]      = 1'b0;
            state_n[ch]               = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[owner_q[ch]]) begin
            write_ready_n[owner_q[ch]] = 1'b0;
            claim_n[owner_q[ch]]       = 1'b0;
            state_n[ch]                = IDLE;
          end
        end
        default: state_n[ch] = IDLE;
      endcase
    end
  end

  // State and registered outputs; memory-side outputs follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
        state_q[ch] <= IDLE;
        owner_q[ch] <= '0;
        addr_q[ch]  <= '0;
        wdata_q[ch] <= '0;
      end
      claim_q              <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
        state_q[ch] <= state_n[ch];
        owner_q[ch] <= owner_n[ch];
        addr_q[ch]  <= addr_n[ch];
        wdata_q[ch] <= wdata_n[ch];
        mem_read_valid[ch]  <= (state_n[ch] == READ_WAITING);
        mem_write_valid[ch] <= (state_n[ch] == WRITE_WAITING);
        mem_read_address[ch*ADDR_BITS +: ADDR_BITS] <=
          (state_n[ch] == READ_WAITING) ? addr_n[ch] : '0;
        mem_write_address[ch*ADDR_BITS +: ADDR_BITS] <=
          (state_n[ch] == WRITE_WAITING) ? addr_n[ch] : '0;
        mem_write_data[ch*DATA_BITS +: DATA_BITS] <=
          (state_n[ch] == WRITE_WAITING) ? wdata_n[ch] : '0;
      end
      claim_q              <= claim_n;
      consumer_read_ready  <= read_ready_n;
      consumer_read_data   <= read_data_n;
      consumer_write_ready <= write_ready_n;
    end
  end

endmodule
